// File: rtl/pccm_pulse_sequencer_if.sv
// rtl/pccm_pulse_sequencer_if.sv - Avalon-MM register bus for the PCCM pulse sequencer
interface pccm_pulse_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/pccm_pulse_sequencer.sv
// rtl/pccm_pulse_sequencer.sv - timed SET/RESET/READ sequencer for the 4-bit PCCM control bus
// Optional irq output and CTRL[7] irq enable when PCCM_SEQ_IRQ_EN is defined.
module pccm_pulse_sequencer #(
    parameter int CW = 16,
    parameter int RW = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pccm_pulse_sequencer_if.slave  bus,
`ifdef PCCM_SEQ_IRQ_EN
    output logic                   irq,
`endif
    output logic [3:0]             out_port
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t        state, state_d;
    logic [3:0]    out_d;
    logic [CW-1:0] pulse_w_q, settle_q;
    logic [RW-1:0] repeat_q;
    logic [CW-1:0] pw_w, st_w, cnt, cnt_d;
    logic [RW-1:0] rem, rem_d;
    logic [1:0]    op_q;
    logic          done_q, aborted_q, irq_en_q;
    logic          launch;

    logic       wr, ctrl_wr, start, abort;
    logic [1:0] wop;
    logic       unused_wdata;

    assign wr           = bus.chipselect & ~bus.write_n;
    assign ctrl_wr      = wr && (bus.address == 2'd0);
    assign start        = ctrl_wr & bus.writedata[0];
    assign abort        = ctrl_wr & bus.writedata[1];
    assign wop          = bus.writedata[3:2];
    assign unused_wdata = ^bus.writedata;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        rem_d   = rem;
        launch  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && !abort && wop != 2'd0) begin
                    state_d = S_SETUP;
                    launch  = 1'b1;
                end
            end
            S_SETUP: begin
                state_d = S_PULSE;
                cnt_d   = pw_w - CW'(1);
            end
            S_PULSE: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CW'(1);
                end else if (st_w != '0) begin
                    state_d = S_SETTLE;
                    cnt_d   = st_w - CW'(1);
                end else if (rem != '0) begin
                    rem_d = rem - RW'(1);
                    cnt_d = pw_w - CW'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_SETTLE: begin
                if (cnt != '0) begin
                    cnt_d = cnt - CW'(1);
                end else if (rem != '0) begin
                    state_d = S_PULSE;
                    rem_d   = rem - RW'(1);
                    cnt_d   = pw_w - CW'(1);
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (abort && state != S_IDLE)
            state_d = S_IDLE;

        // Output is decoded from the next state so it registers on the same edge.
        out_d = 4'b0000;
        case (state_d)
            S_SETUP, S_SETTLE: out_d = 4'b0001;
            S_PULSE:           out_d = 4'b0001 | (4'b0001 << op_q);
            default:           out_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            out_port  <= 4'b0000;
            pulse_w_q <= CW'(1);
            settle_q  <= '0;
            repeat_q  <= '0;
            pw_w      <= CW'(1);
            st_w      <= '0;
            cnt       <= '0;
            rem       <= '0;
            op_q      <= 2'd0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            irq_en_q  <= 1'b0;
        end else begin
            state    <= state_d;
            out_port <= out_d;
            cnt      <= cnt_d;

            if (launch) begin
                op_q      <= wop;
                pw_w      <= (pulse_w_q == '0) ? CW'(1) : pulse_w_q;
                st_w      <= settle_q;
                rem       <= repeat_q;
                done_q    <= 1'b0;
                aborted_q <= 1'b0;
            end else begin
                rem <= rem_d;
                if (abort)
                    aborted_q <= 1'b1;
                else if (state == S_DONE)
                    done_q <= 1'b1;
            end

            if (wr && state == S_IDLE) begin
                case (bus.address)
                    2'd1:    pulse_w_q <= bus.writedata[CW-1:0];
                    2'd2:    settle_q  <= bus.writedata[CW-1:0];
                    2'd3:    repeat_q  <= bus.writedata[RW-1:0];
                    default: ;
                endcase
            end

`ifdef PCCM_SEQ_IRQ_EN
            if (ctrl_wr)
                irq_en_q <= bus.writedata[7];
`else
            irq_en_q <= 1'b0;
`endif
        end
    end

`ifdef PCCM_SEQ_IRQ_EN
    assign irq = done_q & irq_en_q;
`endif

    always_comb begin
        bus.readdata = 32'd0;
        case (bus.address)
            2'd0:    bus.readdata = {24'd0, irq_en_q, aborted_q, done_q, (state != S_IDLE), op_q, 2'b00};
            2'd1:    bus.readdata = 32'(pulse_w_q);
            2'd2:    bus.readdata = 32'(settle_q);
            default: bus.readdata = 32'(repeat_q);
        endcase
    end

endmodule

// File: tb/tb_pccm_pulse_sequencer.sv
// tb/tb_pccm_pulse_sequencer.sv - randomized self-checking bench for pccm_pulse_sequencer
module tb_pccm_pulse_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] out_port;
`ifdef PCCM_SEQ_IRQ_EN
    logic       irq;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    pccm_pulse_sequencer_if bus();

    pccm_pulse_sequencer #(.CW(16), .RW(8)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus.slave),
`ifdef PCCM_SEQ_IRQ_EN
        .irq      (irq),
`endif
        .out_port (out_port)
    );

    // Expected out_port per cycle, starting with the cycle after the start write.
    function automatic void model(int pw, int st, int rep, int op);
        logic [3:0] pulse_val;
        int         pw_eff;
        pulse_val = 4'b0001 | (4'b0001 << op);
        pw_eff    = (pw == 0) ? 1 : pw;
        exp_q.delete();
        exp_q.push_back(4'b0001);
        for (int r = 0; r <= rep; r++) begin
            for (int k = 0; k < pw_eff; k++) exp_q.push_back(pulse_val);
            for (int k = 0; k < st; k++) exp_q.push_back(4'b0001);
        end
        exp_q.push_back(4'b0000);
    endfunction

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        d = bus.readdata;
        bus.chipselect = 1'b0;
    endtask

    task automatic check_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        tests_run++;
        if (v !== exp) begin
            tests_failed++;
            $display("FAIL %s: read 0x%08h, expected 0x%08h", name, v, exp);
        end
    endtask

    task automatic run_seq(input string name, input int pw, input int st, input int rep, input int op);
        model(pw, st, rep, op);
        wr(2'd1, 32'(pw));
        wr(2'd2, 32'(st));
        wr(2'd3, 32'(rep));
        wr(2'd0, 32'((op << 2) | 1));
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            tests_run++;
            if (out_port !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL %s cycle %0d: out_port=%b expected %b", name, i, out_port, exp_q[i]);
            end
        end
        @(negedge clk);
        check_rd({name, "_ctrl_done"}, 2'd0, 32'((op << 2) | 32'h20));
    endtask

    task automatic test_reset();
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;
        reset_n        = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (out_port !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_out_port: out_port=%b expected 0000", out_port);
        end
        check_rd("reset_ctrl", 2'd0, 32'd0);
        check_rd("reset_pulse_w", 2'd1, 32'd1);
        check_rd("reset_settle", 2'd2, 32'd0);
        check_rd("reset_repeat", 2'd3, 32'd0);
    endtask

    task automatic test_set_basic();
        run_seq("set_basic", 3, 2, 1, 1);
    endtask

    task automatic test_read_contiguous();
        run_seq("read_contig", 0, 0, 2, 3);
    endtask

    task automatic test_abort();
        wr(2'd1, 32'd10);
        wr(2'd2, 32'd0);
        wr(2'd3, 32'd0);
        wr(2'd0, 32'h09);
        repeat (4) @(negedge clk);
        tests_run++;
        if (out_port !== 4'b0101) begin
            tests_failed++;
            $display("FAIL abort_pre_pulse: out_port=%b expected 0101", out_port);
        end
        wr(2'd0, 32'h02);
        @(negedge clk);
        tests_run++;
        if (out_port !== 4'b0000) begin
            tests_failed++;
            $display("FAIL abort_out_port: out_port=%b expected 0000", out_port);
        end
        check_rd("abort_ctrl", 2'd0, 32'h48);
    endtask

    task automatic test_busy_writes();
        model(2, 1, 1, 1);
        wr(2'd1, 32'd2);
        wr(2'd2, 32'd1);
        wr(2'd3, 32'd1);
        wr(2'd0, 32'h05);
        wr(2'd1, 32'd7);
        wr(2'd0, 32'h0D);
        for (int i = 2; i < exp_q.size(); i++) begin
            @(negedge clk);
            tests_run++;
            if (out_port !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL busy_writes cycle %0d: out_port=%b expected %b", i, out_port, exp_q[i]);
            end
        end
        @(negedge clk);
        check_rd("busy_pulse_w", 2'd1, 32'd2);
        check_rd("busy_ctrl", 2'd0, 32'h24);
    endtask

    task automatic test_idle_noops();
        wr(2'd0, 32'h01);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_port !== 4'b0000) begin
                tests_failed++;
                $display("FAIL nop_start_out cycle %0d: out_port=%b expected 0000", i, out_port);
            end
        end
        check_rd("nop_start_ctrl", 2'd0, 32'h24);
        wr(2'd0, 32'h0F);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (out_port !== 4'b0000) begin
                tests_failed++;
                $display("FAIL start_abort_out cycle %0d: out_port=%b expected 0000", i, out_port);
            end
        end
        check_rd("start_abort_ctrl", 2'd0, 32'h64);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            int pw, st, rep, op;
            pw  = $urandom_range(0, 5);
            st  = $urandom_range(0, 3);
            rep = $urandom_range(0, 3);
            op  = $urandom_range(1, 3);
            run_seq($sformatf("rand%0d_pw%0d_st%0d_rep%0d_op%0d", n, pw, st, rep, op), pw, st, rep, op);
        end
    endtask

    task automatic test_async_reset();
        wr(2'd1, 32'd6);
        wr(2'd0, 32'h05);
        repeat (3) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        tests_run++;
        if (out_port !== 4'b0000) begin
            tests_failed++;
            $display("FAIL async_reset_out: out_port=%b expected 0000", out_port);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_rd("async_reset_ctrl", 2'd0, 32'd0);
        check_rd("async_reset_pulse_w", 2'd1, 32'd1);
    endtask

    initial begin
        test_reset();
        test_set_basic();
        test_read_contiguous();
        test_abort();
        test_busy_writes();
        test_idle_noops();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
